// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: selects the video timing set driven to the timing driver
// and sequences its reset around mode changes and pixel-PLL lock loss.
//
// Ports:
//   pixel_clk, sys_rst_n      - clock, async active-low reset
//   pll_locked                - PLL lock (synchronous to pixel_clk)
//   video_vs                  - active-low field sync from the driver
//   mode_req_valid/_sel/_ready- mode change request handshake
//   drv_rst_n                 - registered active-low reset to the driver
//   h_* / v_*                 - registered timing set for cur_mode
//   cur_mode, mode_busy, mode_err - status
module video_mode_ctrl #(
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [1:0]  DEF_MODE   = 2'd2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        pll_locked,
  input  logic        video_vs,
  input  logic        mode_req_valid,
  input  logic [1:0]  mode_req_sel,
  output logic        mode_req_ready,
  output logic        drv_rst_n,
  output logic [11:0] h_sync,
  output logic [11:0] h_back,
  output logic [11:0] h_disp,
  output logic [11:0] h_front,
  output logic [11:0] h_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_back,
  output logic [11:0] v_disp,
  output logic [11:0] v_front,
  output logic [11:0] v_total,
  output logic [1:0]  cur_mode,
  output logic        mode_busy,
  output logic        mode_err
);

  localparam int unsigned TW    = 12;
  localparam int unsigned CW    = 8;
  localparam int unsigned TIM_W = 10 * TW;
  localparam logic [1:0]  MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {HOLD_RST, WAIT_LOCK, RUN, WAIT_FRAME} state_t;

  // Timing set packed as {h sync,back,disp,front,total, v sync,back,disp,front,total}.
  function automatic logic [TIM_W-1:0] timing_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return {12'd96, 12'd48,  12'd640,  12'd16,  12'd800,
                       12'd2,  12'd33,  12'd480,  12'd10,  12'd525};
      2'd1:    return {12'd40, 12'd220, 12'd1280, 12'd110, 12'd1650,
                       12'd5,  12'd20,  12'd720,  12'd5,   12'd750};
      default: return {12'd44, 12'd148, 12'd1920, 12'd88,  12'd2200,
                       12'd5,  12'd36,  12'd1080, 12'd4,   12'd1125};
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        cur_mode_q, cur_mode_d;
  logic [1:0]        pending_q, pending_d;
  logic [TIM_W-1:0]  timing_q, timing_d;
  logic              vs_q;
  logic              drv_rst_n_q, drv_rst_n_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              vs_fall;
  logic              accept;
  logic              load_en;
  logic [1:0]        load_mode;

  assign vs_fall = vs_q & ~video_vs;
  // Lock loss wins over a request on the same cycle.
  assign accept  = (state_q == RUN) & mode_req_valid & pll_locked;

  // State register
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= HOLD_RST;
    else            state_q <= state_d;
  end

  // Next-state and timing-load decision
  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    load_mode = cur_mode_q;
    case (state_q)
      HOLD_RST:   if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK:  if (pll_locked) state_d = RUN;
      RUN: begin
        if (!pll_locked) begin
          state_d = HOLD_RST;
          load_en = 1'b1;
        end else if (accept && mode_req_sel != MODE_RSVD && mode_req_sel != cur_mode_q) begin
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (!pll_locked || vs_fall) begin
          state_d   = HOLD_RST;
          load_en   = 1'b1;
          load_mode = pending_q;
        end
      end
      default:    state_d = HOLD_RST;
    endcase
  end

  // Output / datapath next values, derived from the next state so the
  // registered outputs line up with the state register.
  always_comb begin
    drv_rst_n_d = (state_d == RUN) || (state_d == WAIT_FRAME);
    ready_d     = (state_d == RUN);
    busy_d      = (state_d != RUN);
    err_d       = accept && (mode_req_sel == MODE_RSVD);
    cnt_d       = (state_q == HOLD_RST && state_d == HOLD_RST) ? cnt_q + CW'(1) : '0;
    pending_d   = pending_q;
    if (accept && mode_req_sel != MODE_RSVD && mode_req_sel != cur_mode_q)
      pending_d = mode_req_sel;
    cur_mode_d  = load_en ? load_mode : cur_mode_q;
    timing_d    = load_en ? timing_of(load_mode) : timing_q;
  end

  // Datapath and output registers
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      cur_mode_q  <= DEF_MODE;
      pending_q   <= DEF_MODE;
      timing_q    <= timing_of(DEF_MODE);
      vs_q        <= 1'b1;
      drv_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_mode_q  <= cur_mode_d;
      pending_q   <= pending_d;
      timing_q    <= timing_d;
      vs_q        <= video_vs;
      drv_rst_n_q <= drv_rst_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign {h_sync, h_back, h_disp, h_front, h_total,
          v_sync, v_back, v_disp, v_front, v_total} = timing_q;
  assign cur_mode       = cur_mode_q;
  assign drv_rst_n      = drv_rst_n_q;
  assign mode_req_ready = ready_q;
  assign mode_busy      = busy_q;
  assign mode_err       = err_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: power-up, mode change, invalid/same
// requests, lock loss, collisions and async reset in WAIT_FRAME.
module tb_video_mode_ctrl;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n;
  logic        pll_locked;
  logic        video_vs;
  logic        mode_req_valid;
  logic [1:0]  mode_req_sel;
  logic        mode_req_ready;
  logic        drv_rst_n;
  logic [11:0] h_sync, h_back, h_disp, h_front, h_total;
  logic [11:0] v_sync, v_back, v_disp, v_front, v_total;
  logic [1:0]  cur_mode;
  logic        mode_busy;
  logic        mode_err;

  int checks = 0;
  int errors = 0;

  video_mode_ctrl #(.RST_CYCLES(16), .DEF_MODE(2'd2)) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked),
    .video_vs(video_vs), .mode_req_valid(mode_req_valid),
    .mode_req_sel(mode_req_sel), .mode_req_ready(mode_req_ready),
    .drv_rst_n(drv_rst_n),
    .h_sync(h_sync), .h_back(h_back), .h_disp(h_disp), .h_front(h_front), .h_total(h_total),
    .v_sync(v_sync), .v_back(v_back), .v_disp(v_disp), .v_front(v_front), .v_total(v_total),
    .cur_mode(cur_mode), .mode_busy(mode_busy), .mode_err(mode_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample/drive at the following falling edge.
  task automatic tick();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  // From HOLD_RST entry: 16 cycles of HOLD plus one WAIT_LOCK with lock high.
  task automatic wait_run(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, "_drv_low"}, 32'(drv_rst_n), 32'd0);
    end
    tick();
    chk({tag, "_drv_high"}, 32'(drv_rst_n), 32'd1);
    chk({tag, "_busy"}, 32'(mode_busy), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0; pll_locked = 1'b1; video_vs = 1'b1;
    mode_req_valid = 1'b0; mode_req_sel = 2'd0;
    #12;
    // Reset state
    chk("rst_drv", 32'(drv_rst_n), 32'd0);
    chk("rst_ready", 32'(mode_req_ready), 32'd0);
    chk("rst_busy", 32'(mode_busy), 32'd1);
    chk("rst_err", 32'(mode_err), 32'd0);
    chk("rst_mode", 32'(cur_mode), 32'd2);
    chk("rst_htot", 32'(h_total), 32'd2200);
    chk("rst_vtot", 32'(v_total), 32'd1125);
    @(negedge pixel_clk);
    sys_rst_n = 1'b1;

    // Power-up: drv_rst_n rises after 16 HOLD + 1 WAIT_LOCK cycles
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("pwr_drv_low", 32'(drv_rst_n), 32'd0);
    end
    tick();
    chk("pwr_drv_high", 32'(drv_rst_n), 32'd1);
    chk("pwr_ready", 32'(mode_req_ready), 32'd1);
    chk("pwr_hdisp", 32'(h_disp), 32'd1920);

    // Mode change to 1, vs falls 100 cycles after acceptance
    mode_req_valid = 1'b1; mode_req_sel = 2'd1;
    tick();
    mode_req_valid = 1'b0;
    chk("mc_ready", 32'(mode_req_ready), 32'd0);
    chk("mc_busy", 32'(mode_busy), 32'd1);
    for (int i = 0; i < 99; i++) begin
      tick();
      chk("mc_hold_htot", 32'(h_total), 32'd2200);
      chk("mc_hold_drv", 32'(drv_rst_n), 32'd1);
    end
    video_vs = 1'b0;
    tick();
    video_vs = 1'b1;
    chk("mc_htot", 32'(h_total), 32'd1650);
    chk("mc_vdisp", 32'(v_disp), 32'd720);
    chk("mc_hsync", 32'(h_sync), 32'd40);
    chk("mc_mode", 32'(cur_mode), 32'd1);
    chk("mc_drv", 32'(drv_rst_n), 32'd0);
    wait_run("mc");

    // Reserved mode: one-cycle error, stays in RUN
    mode_req_valid = 1'b1; mode_req_sel = 2'd3;
    tick();
    mode_req_valid = 1'b0;
    chk("inv_err", 32'(mode_err), 32'd1);
    chk("inv_busy", 32'(mode_busy), 32'd0);
    tick();
    chk("inv_err_clr", 32'(mode_err), 32'd0);
    chk("inv_mode", 32'(cur_mode), 32'd1);

    // Same mode: no action
    mode_req_valid = 1'b1; mode_req_sel = 2'd1;
    tick();
    mode_req_valid = 1'b0;
    chk("same_busy", 32'(mode_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("same_drv", 32'(drv_rst_n), 32'd1);
    end

    // Lock loss in WAIT_FRAME with pending mode 0
    mode_req_valid = 1'b1; mode_req_sel = 2'd0;
    tick();
    mode_req_valid = 1'b0;
    tick();
    chk("ll_wf_busy", 32'(mode_busy), 32'd1);
    chk("ll_wf_htot", 32'(h_total), 32'd1650);
    pll_locked = 1'b0;
    tick();
    chk("ll_drv", 32'(drv_rst_n), 32'd0);
    chk("ll_htot", 32'(h_total), 32'd800);
    chk("ll_vtot", 32'(v_total), 32'd525);
    chk("ll_mode", 32'(cur_mode), 32'd0);
    for (int i = 0; i < 26; i++) begin
      tick();
      chk("ll_wait_drv", 32'(drv_rst_n), 32'd0);
      chk("ll_wait_busy", 32'(mode_busy), 32'd1);
    end
    pll_locked = 1'b1;
    tick();
    chk("ll_relock_drv", 32'(drv_rst_n), 32'd1);

    // Request collides with lock loss: not accepted
    mode_req_valid = 1'b1; mode_req_sel = 2'd2; pll_locked = 1'b0;
    tick();
    mode_req_valid = 1'b0; pll_locked = 1'b1;
    chk("col_drv", 32'(drv_rst_n), 32'd0);
    chk("col_err", 32'(mode_err), 32'd0);
    chk("col_mode", 32'(cur_mode), 32'd0);
    wait_run("col");
    tick();
    chk("col_no_wf", 32'(mode_busy), 32'd0);
    chk("col_htot", 32'(h_total), 32'd800);

    // Held request: ready low through WAIT_FRAME/HOLD_RST, accepted in RUN
    mode_req_valid = 1'b1; mode_req_sel = 2'd1;
    tick();
    mode_req_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hs_wf_ready", 32'(mode_req_ready), 32'd0);
    end
    video_vs = 1'b0;
    tick();
    video_vs = 1'b1;
    chk("hs_mode", 32'(cur_mode), 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("hs_hold_ready", 32'(mode_req_ready), 32'd0);
    end
    tick();
    chk("hs_run_ready", 32'(mode_req_ready), 32'd1);
    tick();
    mode_req_valid = 1'b0;
    chk("hs_accepted", 32'(mode_busy), 32'd1);
    chk("hs_acc_ready", 32'(mode_req_ready), 32'd0);

    // Async reset in WAIT_FRAME (pending 0): immediate DEF_MODE outputs
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("ar_htot", 32'(h_total), 32'd2200);
    chk("ar_vdisp", 32'(v_disp), 32'd1080);
    chk("ar_mode", 32'(cur_mode), 32'd2);
    chk("ar_drv", 32'(drv_rst_n), 32'd0);
    chk("ar_busy", 32'(mode_busy), 32'd1);
    @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    video_vs = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    video_vs = 1'b1;
    tick();
    chk("ar_run_drv", 32'(drv_rst_n), 32'd1);
    chk("ar_run_mode", 32'(cur_mode), 32'd2);
    chk("ar_run_htot", 32'(h_total), 32'd2200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
